// File: rtl/writeback_arb_pkg.sv
// Shared X__W definitions: default widths and the payload record that every
// execute unit hands to writeback.
package writeback_arb_pkg;

   localparam int XW_NUM_PIPES     = 3;
   localparam int XW_ADDR_BITS     = 32;
   localparam int XW_DATA_BITS     = 32;
   localparam int XW_SEQ_NUM_BITS  = 5;
   localparam int XW_REG_ADDR_BITS = 5;

   // One completed result as produced by an execute pipe.
   typedef struct packed {
      logic [XW_ADDR_BITS-1:0]     pc;
      logic [XW_SEQ_NUM_BITS-1:0]  seq_num;
      logic [XW_REG_ADDR_BITS-1:0] waddr;
      logic [XW_DATA_BITS-1:0]     wdata;
      logic                        wen;
   } xw_payload_t;

endpackage

// File: rtl/writeback_arb_if.sv
// X__W bundle from the execute pipes into writeback, together with the
// register-file write port and the completion report driven by writeback.
interface writeback_arb_if
   import writeback_arb_pkg::*;
#(
   parameter int p_num_pipes    = XW_NUM_PIPES,
   parameter int p_addr_bits    = XW_ADDR_BITS,
   parameter int p_data_bits    = XW_DATA_BITS,
   parameter int p_seq_num_bits = XW_SEQ_NUM_BITS
) ();

   logic [p_num_pipes-1:0]                  Ex_val;
   logic [p_num_pipes-1:0]                  Ex_rdy;
   logic [p_num_pipes*p_addr_bits-1:0]      Ex_pc;
   logic [p_num_pipes*p_seq_num_bits-1:0]   Ex_seq_num;
   logic [p_num_pipes*XW_REG_ADDR_BITS-1:0] Ex_waddr;
   logic [p_num_pipes*p_data_bits-1:0]      Ex_wdata;
   logic [p_num_pipes-1:0]                  Ex_wen;

   logic                        rf_wen;
   logic [XW_REG_ADDR_BITS-1:0] rf_waddr;
   logic [p_data_bits-1:0]      rf_wdata;

   logic                        cmpl_val;
   logic [p_addr_bits-1:0]      cmpl_pc;
   logic [p_seq_num_bits-1:0]   cmpl_seq_num;

   // Execute side (and anything observing the register-file/commit outputs).
   modport master (
      output Ex_val, Ex_pc, Ex_seq_num, Ex_waddr, Ex_wdata, Ex_wen,
      input  Ex_rdy,
      input  rf_wen, rf_waddr, rf_wdata,
      input  cmpl_val, cmpl_pc, cmpl_seq_num
   );

   // Writeback side.
   modport slave (
      input  Ex_val, Ex_pc, Ex_seq_num, Ex_waddr, Ex_wdata, Ex_wen,
      output Ex_rdy,
      output rf_wen, rf_waddr, rf_wdata,
      output cmpl_val, cmpl_pc, cmpl_seq_num
   );

endinterface

// File: rtl/writeback_arb_rr_arb.sv
// Round-robin arbiter: one-hot grant searched from ptr upward with wrap; the
// pointer moves past the winner only when the grant is actually taken.
module writeback_arb_rr_arb
   import writeback_arb_pkg::*;
#(
   parameter int p_width = XW_NUM_PIPES
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [p_width-1:0] req_i,
   input  logic               xfer_i,
   output logic [p_width-1:0] gnt_o
);

   localparam int PTR_BITS = (p_width > 1) ? $clog2(p_width) : 1;

   generate
      if (p_width == 1) begin : g_single
         // A lone producer is always granted; there is nothing to rotate.
         assign gnt_o = 1'b1;
      end else begin : g_rr
         localparam logic [PTR_BITS-1:0] LAST = PTR_BITS'(p_width - 1);

         logic [PTR_BITS-1:0] ptr_q, ptr_d;
         logic [PTR_BITS-1:0] idx;
         logic [PTR_BITS-1:0] idx_inc;
         logic                found;

         // NOTE: every variable gets a default before the search loop, so no
         // path leaves one unassigned and no latch is inferred.
         always_comb begin
            gnt_o   = '0;
            ptr_d   = ptr_q;
            found   = 1'b0;
            idx     = ptr_q;
            idx_inc = '0;
            for (int off = 0; off < p_width; off++) begin
               idx_inc = (idx == LAST) ? '0 : idx + PTR_BITS'(1);
               if (!found && req_i[idx]) begin
                  found      = 1'b1;
                  gnt_o[idx] = 1'b1;
                  ptr_d      = idx_inc;
               end
               idx = idx_inc;
            end
         end

         // NOTE: state is updated with non-blocking assignments only.
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               ptr_q <= '0;
            end else if (xfer_i) begin
               ptr_q <= ptr_d;
            end
         end
      end
   endgenerate

endmodule

// File: rtl/writeback_arb.sv
// Writeback stage: picks one finished result per cycle from the execute pipes,
// registers it, and next cycle writes the register file and reports completion.
module writeback_arb
   import writeback_arb_pkg::*;
#(
   parameter int p_num_pipes    = XW_NUM_PIPES,
   parameter int p_addr_bits    = XW_ADDR_BITS,
   parameter int p_data_bits    = XW_DATA_BITS,
   parameter int p_seq_num_bits = XW_SEQ_NUM_BITS
) (
   input  logic           clk,
   input  logic           rst,
   writeback_arb_if.slave xw
);

   localparam int RB = XW_REG_ADDR_BITS;

   typedef struct packed {
      logic [p_addr_bits-1:0]    pc;
      logic [p_seq_num_bits-1:0] seq_num;
      logic [RB-1:0]             waddr;
      logic [p_data_bits-1:0]    wdata;
      logic                      wen;
   } stage_t;

   logic [p_num_pipes-1:0] gnt;
   logic                   xfer;
   logic                   val_q;
   stage_t                 stage_q;
   stage_t                 stage_d;

   writeback_arb_rr_arb #(
      .p_width (p_num_pipes)
   ) u_rr_arb (
      .clk    (clk),
      .rst    (rst),
      .req_i  (xw.Ex_val),
      .xfer_i (xfer),
      .gnt_o  (gnt)
   );

   // W never stalls, so the grant is the ready and any granted valid transfers.
   assign xw.Ex_rdy = gnt;
   assign xfer      = |(xw.Ex_val & gnt);

   // Grant is one-hot, so selecting by it is a plain mux of the winner's fields.
   always_comb begin
      stage_d = '0;
      for (int i = 0; i < p_num_pipes; i++) begin
         if (gnt[i]) begin
            stage_d.pc      = xw.Ex_pc[i*p_addr_bits +: p_addr_bits];
            stage_d.seq_num = xw.Ex_seq_num[i*p_seq_num_bits +: p_seq_num_bits];
            stage_d.waddr   = xw.Ex_waddr[i*RB +: RB];
            stage_d.wdata   = xw.Ex_wdata[i*p_data_bits +: p_data_bits];
            stage_d.wen     = xw.Ex_wen[i];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         val_q <= 1'b0;
      end else begin
         val_q <= xfer;
      end
   end

   // NOTE: the payload carries no reset; val_q alone qualifies it, so a reset
   // discards the in-flight entry without touching these flops.
   always_ff @(posedge clk) begin
      if (xfer) begin
         stage_q <= stage_d;
      end
   end

   // x0 is hardwired: the write is dropped but the instruction still completes.
   assign xw.rf_wen       = val_q & stage_q.wen & (stage_q.waddr != '0);
   assign xw.rf_waddr     = stage_q.waddr;
   assign xw.rf_wdata     = stage_q.wdata;

   assign xw.cmpl_val     = val_q;
   assign xw.cmpl_pc      = stage_q.pc;
   assign xw.cmpl_seq_num = stage_q.seq_num;

endmodule

// File: tb/tb_writeback_arb.sv
// Directed and random checks of writeback_arb against a round-robin model that
// tracks the expected winner and the expected stage contents per cycle.
module tb_writeback_arb;
   import writeback_arb_pkg::*;

   localparam int N  = 3;
   localparam int AB = 32;
   localparam int DB = 32;
   localparam int SB = 5;
   localparam int RB = XW_REG_ADDR_BITS;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   writeback_arb_if #(
      .p_num_pipes(N), .p_addr_bits(AB), .p_data_bits(DB), .p_seq_num_bits(SB)
   ) bus ();

   writeback_arb #(
      .p_num_pipes(N), .p_addr_bits(AB), .p_data_bits(DB), .p_seq_num_bits(SB)
   ) dut (
      .clk (clk),
      .rst (rst),
      .xw  (bus)
   );

   // Producer-side stimulus.
   xw_payload_t src [];
   bit          val_a [];

   // Reference model state.
   int          m_ptr;
   bit          e_val;
   xw_payload_t e_pl;

   int n_total = 0;
   int n_pass  = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive();
      for (int i = 0; i < N; i++) begin
         bus.Ex_val[i]               = val_a[i];
         bus.Ex_pc[i*AB +: AB]       = src[i].pc;
         bus.Ex_seq_num[i*SB +: SB]  = src[i].seq_num;
         bus.Ex_waddr[i*RB +: RB]    = src[i].waddr;
         bus.Ex_wdata[i*DB +: DB]    = src[i].wdata;
         bus.Ex_wen[i]               = src[i].wen;
      end
   endtask

   function automatic xw_payload_t rand_pl();
      xw_payload_t p;
      p.pc      = $urandom;
      p.seq_num = SB'($urandom);
      p.waddr   = RB'($urandom);
      p.wdata   = $urandom;
      p.wen     = 1'($urandom);
      return p;
   endfunction

   function automatic xw_payload_t mk_pl(input logic [AB-1:0] pc, input logic [SB-1:0] seq,
                                         input logic [RB-1:0] wa, input logic [DB-1:0] wd,
                                         input logic we);
      xw_payload_t p;
      p.pc = pc; p.seq_num = seq; p.waddr = wa; p.wdata = wd; p.wen = we;
      return p;
   endfunction

   // Round-robin rule: first requester at or after the pointer, wrapping.
   function automatic int model_winner();
      for (int off = 0; off < N; off++) begin
         if (val_a[(m_ptr + off) % N]) return (m_ptr + off) % N;
      end
      return -1;
   endfunction

   task automatic check_outputs(input string tag);
      bit exp_wen;
      exp_wen = e_val && e_pl.wen && (e_pl.waddr != '0);
      check({tag, ".cmpl_val"}, 64'(bus.cmpl_val), 64'(e_val));
      check({tag, ".rf_wen"},   64'(bus.rf_wen),   64'(exp_wen));
      if (e_val) begin
         check({tag, ".cmpl_pc"},  64'(bus.cmpl_pc),      64'(e_pl.pc));
         check({tag, ".cmpl_seq"}, 64'(bus.cmpl_seq_num), 64'(e_pl.seq_num));
      end
      if (exp_wen) begin
         check({tag, ".rf_waddr"}, 64'(bus.rf_waddr), 64'(e_pl.waddr));
         check({tag, ".rf_wdata"}, 64'(bus.rf_wdata), 64'(e_pl.wdata));
      end
   endtask

   // Entered and left at posedge+1: checks grant and stage outputs mid-cycle,
   // then advances the model across the edge.
   task automatic cycle(output int w, output logic [N-1:0] g);
      logic [N-1:0] exp_rdy;
      int           w_l;
      @(negedge clk);
      w_l     = model_winner();
      exp_rdy = '0;
      if (w_l >= 0) exp_rdy = N'(1) << w_l;
      g = bus.Ex_rdy;
      check("ex_rdy", 64'(bus.Ex_rdy), 64'(exp_rdy));
      check_outputs("stage");
      @(posedge clk);
      #1;
      if (w_l >= 0) begin
         e_val = 1'b1;
         e_pl  = src[w_l];
         m_ptr = (w_l + 1) % N;
      end else begin
         e_val = 1'b0;
      end
      w = w_l;
   endtask

   task automatic clear_inputs();
      for (int i = 0; i < N; i++) begin
         val_a[i] = 1'b0;
         src[i]   = '0;
      end
      drive();
   endtask

   // Assert reset between edges, release it at a negedge, resume at posedge+1.
   task automatic do_reset();
      rst = 1'b0;
      #1;
      check("rst.cmpl_val", 64'(bus.cmpl_val), 64'd0);
      check("rst.rf_wen",   64'(bus.rf_wen),   64'd0);
      clear_inputs();
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      m_ptr = 0;
      e_val = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int           w;
      logic [N-1:0] g;
      logic [N-1:0] order [6];

      src   = new[N];
      val_a = new[N];
      m_ptr = 0;
      e_val = 1'b0;
      e_pl  = '0;
      clear_inputs();

      // Reset state.
      #3;
      do_reset();

      // Single pipe transfer and one-cycle latency.
      src[0]   = mk_pl(32'h0000_1000, 5'd3, 5'd5, 32'hDEAD_BEEF, 1'b1);
      val_a[0] = 1'b1;
      drive();
      cycle(w, g);
      check("single.gnt", 64'(g), 64'b001);
      val_a[0] = 1'b0;
      drive();
      check("single.rf_wen",   64'(bus.rf_wen),       64'd1);
      check("single.rf_waddr", 64'(bus.rf_waddr),     64'd5);
      check("single.rf_wdata", 64'(bus.rf_wdata),     64'hDEAD_BEEF);
      check("single.cmpl_val", 64'(bus.cmpl_val),     64'd1);
      check("single.cmpl_seq", 64'(bus.cmpl_seq_num), 64'd3);

      // x0 write from pipe1, then a store (wen=0) from pipe2.
      cycle(w, g);
      src[1]   = mk_pl(32'h0000_2000, 5'd4, 5'd0, 32'h1234_5678, 1'b1);
      val_a[1] = 1'b1;
      drive();
      cycle(w, g);
      val_a[1] = 1'b0;
      src[2]   = mk_pl(32'h0000_3000, 5'd6, 5'd9, 32'hCAFE_F00D, 1'b0);
      val_a[2] = 1'b1;
      drive();
      check("x0.cmpl_val", 64'(bus.cmpl_val), 64'd1);
      check("x0.rf_wen",   64'(bus.rf_wen),   64'd0);
      cycle(w, g);
      val_a[2] = 1'b0;
      drive();
      check("store.cmpl_val", 64'(bus.cmpl_val), 64'd1);
      check("store.rf_wen",   64'(bus.rf_wen),   64'd0);
      check("store.cmpl_seq", 64'(bus.cmpl_seq_num), 64'd6);
      cycle(w, g);

      // Contention from reset: all pipes hold valid for six cycles.
      do_reset();
      order = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
      for (int i = 0; i < N; i++) begin
         src[i]   = rand_pl();
         src[i].seq_num = SB'(i);
         val_a[i] = 1'b1;
      end
      drive();
      for (int k = 0; k < 6; k++) begin
         cycle(w, g);
         check($sformatf("contend.gnt%0d", k), 64'(g), 64'(order[k]));
         if (w >= 0) begin
            src[w] = rand_pl();
            src[w].seq_num = SB'(k + N);
         end
         drive();
      end
      clear_inputs();
      cycle(w, g);

      // Fairness and wrap: steer ptr to 2, then only pipes 0 and 1 request.
      do_reset();
      src[1]   = rand_pl();
      val_a[1] = 1'b1;
      drive();
      cycle(w, g);
      src[0]   = rand_pl();
      src[1]   = rand_pl();
      val_a[0] = 1'b1;
      drive();
      cycle(w, g);
      check("wrap.gnt_pipe0", 64'(g), 64'b001);
      src[0] = rand_pl();
      drive();
      cycle(w, g);
      check("wrap.gnt_pipe1", 64'(g), 64'b010);
      clear_inputs();
      cycle(w, g);

      // Async reset while a stage entry is valid.
      src[2]   = mk_pl(32'h0000_4000, 5'd17, 5'd12, 32'h0BAD_F00D, 1'b1);
      val_a[2] = 1'b1;
      drive();
      cycle(w, g);
      check("areset.pre_cmpl_val", 64'(bus.cmpl_val), 64'd1);
      check("areset.pre_rf_wen",   64'(bus.rf_wen),   64'd1);
      #2;
      do_reset();
      val_a[1] = 1'b1;
      val_a[2] = 1'b1;
      src[1]   = rand_pl();
      src[2]   = rand_pl();
      drive();
      cycle(w, g);
      check("areset.first_gnt", 64'(g), 64'b010);
      clear_inputs();
      cycle(w, g);

      // Random traffic: losers hold, winners drop or refill at random.
      for (int k = 0; k < 300; k++) begin
         for (int i = 0; i < N; i++) begin
            if (!val_a[i] && ($urandom_range(0, 1) == 1)) begin
               val_a[i] = 1'b1;
               src[i]   = rand_pl();
            end
         end
         drive();
         cycle(w, g);
         if (w >= 0) val_a[w] = 1'b0;
      end
      clear_inputs();
      cycle(w, g);
      cycle(w, g);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/writeback_arb.md
Name: writeback_arb

Overview:
- W-side endpoint of the X__W interface: receives completed results from p_num_pipes execute units (ALU, multiplier, memory), arbitrates among them round-robin, and registers one winner per cycle.
- Next cycle it writes the architectural register file and reports completion (pc, seq_num) to the commit/linetrace side.
- Sits between the execute units and the register file; it is the only register-file write port.

Parameters:
- p_num_pipes, 3, number of X__W producers (>=1)
- p_addr_bits, 32, PC width
- p_data_bits, 32, data width
- p_seq_num_bits, 5, sequence number width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset (0 = reset asserted)
- Ex_val  in  p_num_pipes  per-pipe X__W valid
- Ex_rdy  out  p_num_pipes  per-pipe X__W ready (grant)
- Ex_pc  in  p_num_pipes*p_addr_bits  per-pipe PC
- Ex_seq_num  in  p_num_pipes*p_seq_num_bits  per-pipe sequence number
- Ex_waddr  in  p_num_pipes*5  per-pipe destination register
- Ex_wdata  in  p_num_pipes*p_data_bits  per-pipe result
- Ex_wen  in  p_num_pipes  per-pipe write enable
- rf_wen  out  1  register file write enable
- rf_waddr  out  5  register file write address
- rf_wdata  out  p_data_bits  register file write data
- cmpl_val  out  1  instruction completed this cycle
- cmpl_pc  out  p_addr_bits  completed PC
- cmpl_seq_num  out  p_seq_num_bits  completed sequence number

Behaviour:
- Reset (rst==0, async): stage val=0, rr pointer=0. rf_wen=0, cmpl_val=0; all other outputs undefined ('x acceptable).
- Handshake: per pipe, transfer when Ex_val[i] & Ex_rdy[i]. Ex_rdy is a one-hot grant or all-zero; it may depend combinationally on Ex_val, and producers must not make Ex_val depend on Ex_rdy. No backpressure into W: the stage drains every cycle, so a grant is issued every cycle any Ex_val is high.
- Arbitration: round-robin. Search starts at index ptr and wraps mod p_num_pipes; the first asserted Ex_val wins. After a transfer from pipe k, ptr <= (k+1) mod p_num_pipes. With no transfer, ptr holds. With p_num_pipes=1, Ex_rdy=1 always.
- Stage register: on a transfer, latch {val=1, pc, seq_num, waddr, wdata, wen} from the winner. With no transfer, val<=0.
- Latency: a transfer in cycle t produces rf write and completion in cycle t+1, driven combinationally from the stage register.
- rf_wen = val & wen & (waddr!=0). Writes to x0 are suppressed, but x0 writes still complete.
- cmpl_val = val, regardless of wen.
- Lost grants: losers keep Ex_val high and hold data; they are guaranteed a grant within p_num_pipes cycles.
- Reset mid-operation: the in-flight stage entry is discarded with no rf write, and ptr returns to 0.
- Linetrace (non-synthesis): on cmpl_val, print winner index:seq_num:waddr:wdata; otherwise print fixed-width blanks.

Decomposition:
- Shared package (UArch): no new types. Add a shared X__W payload struct typedef (pc, seq_num, waddr, wdata, wen), parameterised by localparams, for reuse by execute units.
- Sub-module rr_arb (parameter p_width): inputs req and xfer-qualified grant update; output one-hot gnt; owns the pointer. Reusable for the D->X issue side.

Test Plan:
- Single pipe: pipe0 sends waddr=5, wdata=0xDEADBEEF, wen=1, seq_num=3 -> Ex_rdy[0]=1 same cycle; next cycle rf_wen=1, rf_waddr=5, rf_wdata=0xDEADBEEF, cmpl_val=1, cmpl_seq_num=3.
- x0 write: waddr=0, wen=1 -> cmpl_val=1, rf_wen=0.
- No-write uop (wen=0, e.g. a store) -> cmpl_val=1, rf_wen=0.
- Contention: all 3 pipes hold val for 6 cycles from reset -> grants in order 0,1,2,0,1,2; completions follow one cycle later with the matching seq_nums.
- Fairness and wrap: ptr=2 with only pipes 0 and 1 valid -> pipe0 granted, ptr becomes 1; next cycle pipe1 granted.
- Async reset: assert rst=0 mid-cycle while a stage entry is valid -> rf_wen and cmpl_val drop to 0 immediately (before the next clk edge). After release, the first grant goes to the lowest valid index.
